// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring integer divider (signed/unsigned).
// One WIDTH-bit subtract (add of inverted divisor, carry-in 1) is iterated
// once per clock over WIDTH cycles, followed by a sign-fixup cycle.
//
// Handshake: start is sampled only while busy=0. The edge that samples
// start=1 accepts the operation and captures a/b/is_signed; busy stays high
// until the fixup edge, which raises done for exactly one cycle together
// with new quo/rem/div_by_zero. start may be asserted in the done cycle to
// begin the next operation on that same edge.
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_signed,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quo,
   output logic [WIDTH-1:0] rem,
   output logic             div_by_zero,
   output logic [1:0]       o_dbg_state
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;        // raw dividend, returned as rem on divide-by-zero
   logic [WIDTH-1:0] r_dvd;      // dividend magnitude, shifts out; quotient bits shift in
   logic [WIDTH-1:0] r_rem_acc;  // partial remainder
   logic [WIDTH-1:0] r_bmag;     // divisor magnitude
   logic             r_sign_q;   // quotient must be negated
   logic             r_sign_r;   // remainder must be negated (follows dividend)
   logic             r_dz;       // captured divisor was zero
   logic             r_done;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_rem;
   logic             r_div_by_zero;

   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH-1:0] w_shift;
   logic             w_shift_ovf;
   logic [WIDTH:0]   w_sum;
   logic             w_take;
   logic [WIDTH-1:0] w_quo_fix;
   logic [WIDTH-1:0] w_rem_fix;

   // Operand magnitudes at accept time; wraparound negation makes the
   // most-negative value its own magnitude, which the unsigned core handles.
   assign w_a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
   assign w_b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

   // One restoring step. The bit shifted out of rem_acc is kept so that a
   // shifted value >= 2^WIDTH (large unsigned divisors) still subtracts.
   assign w_shift     = {r_rem_acc[WIDTH-2:0], r_dvd[WIDTH-1]};
   assign w_shift_ovf = r_rem_acc[WIDTH-1];
   assign w_sum       = {1'b0, w_shift} + {1'b0, ~r_bmag} + (WIDTH+1)'(1);
   assign w_take      = w_shift_ovf | w_sum[WIDTH];

   // Sign fixup: truncation toward zero.
   assign w_quo_fix = r_sign_q ? -r_dvd : r_dvd;
   assign w_rem_fix = r_sign_r ? -r_rem_acc : r_rem_acc;

   // Control FSM and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_a           <= '0;
         r_dvd         <= '0;
         r_rem_acc     <= '0;
         r_bmag        <= '0;
         r_sign_q      <= 1'b0;
         r_sign_r      <= 1'b0;
         r_dz          <= 1'b0;
         r_done        <= 1'b0;
         r_quo         <= '0;
         r_rem         <= '0;
         r_div_by_zero <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a       <= a;
                  r_dvd     <= w_a_mag;
                  r_bmag    <= w_b_mag;
                  r_rem_acc <= '0;
                  r_cnt     <= CW'(WIDTH);
                  r_sign_q  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_sign_r  <= is_signed & a[WIDTH-1];
                  r_dz      <= (b == '0);
                  r_state   <= (b == '0) ? S_FIX : S_RUN;
               end
            end
            S_RUN: begin
               r_dvd     <= {r_dvd[WIDTH-2:0], w_take};
               r_rem_acc <= w_take ? w_sum[WIDTH-1:0] : w_shift;
               r_cnt     <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_done        <= 1'b1;
               r_div_by_zero <= r_dz;
               r_quo         <= r_dz ? '1 : w_quo_fix;
               r_rem         <= r_dz ? r_a : w_rem_fix;
               r_state       <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy        = (r_state != S_IDLE);
   assign done        = r_done;
   assign quo         = r_quo;
   assign rem         = r_rem;
   assign div_by_zero = r_div_by_zero;
   assign o_dbg_state = r_state;

endmodule
